// File: rtl/stack_ctrl.sv
// stack_ctrl: return-stack sequencer for the PIC16F84 core.
// Arbitrates interrupt entry, CALL and RETURN/RETLW/RETFIE requests, drives the
// 8-level stack strobes, captures return addresses and issues a one-cycle PC load.
// Optional feature macro: STACK_CTRL_DEPTH_CHECK_EN (sticky overflow/underflow
// flags, pop strobes suppressed on an empty stack). Undefined: silent wrap.
module stack_ctrl #(
    parameter int unsigned     DEPTH   = 8,
    parameter int unsigned     AW      = 10,
    parameter logic [AW-1:0]   INT_VEC = 'h004
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          call_req,
    input  logic          ret_req,
    input  logic          retfie,
    input  logic          int_req,
    input  logic [AW-1:0] cur_pc,
    input  logic [AW-1:0] stk_top,
    output logic [AW-1:0] push_pc,
    output logic          stk_en,
    output logic          stk_push,
    output logic          stk_pop,
    output logic          pc_load,
    output logic [1:0]    pc_src,
    output logic [AW-1:0] ret_pc,
    output logic          ack,
    output logic          busy,
    output logic          gie_clr,
    output logic          gie_set,
    output logic [3:0]    depth,
    output logic          overflow,
    output logic          underflow
);

    typedef enum logic [1:0] {StIdle, StPush, StPop, StLoad} state_e;

    // PC source encodings as seen by the PC mux
    localparam logic [1:0] SrcNone = 2'b00;
    localparam logic [1:0] SrcCall = 2'b01;
    localparam logic [1:0] SrcInt  = 2'b10;
    localparam logic [1:0] SrcRet  = 2'b11;

    localparam logic [3:0] DepthMax = 4'(DEPTH);

    // The vector itself is applied by the PC mux; kept here so both agree on it
    logic [AW-1:0] int_vec_unused;
    assign int_vec_unused = INT_VEC;

    state_e     state_q;
    logic [1:0] kind_q;
    logic       retfie_q;
    logic       ovf_q;
    logic       unf_q;

`ifdef STACK_CTRL_DEPTH_CHECK_EN
    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    // Sequencer FSM with all outputs registered; strobes default low every cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            kind_q   <= SrcNone;
            retfie_q <= 1'b0;
            push_pc  <= '0;
            ret_pc   <= '0;
            stk_en   <= 1'b0;
            stk_push <= 1'b0;
            stk_pop  <= 1'b0;
            pc_load  <= 1'b0;
            pc_src   <= SrcNone;
            ack      <= 1'b0;
            busy     <= 1'b0;
            gie_clr  <= 1'b0;
            gie_set  <= 1'b0;
            depth    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            stk_en   <= 1'b0;
            stk_push <= 1'b0;
            stk_pop  <= 1'b0;
            pc_load  <= 1'b0;
            pc_src   <= SrcNone;
            ack      <= 1'b0;
            gie_clr  <= 1'b0;
            gie_set  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (int_req || call_req) begin
                        push_pc  <= cur_pc;
                        kind_q   <= int_req ? SrcInt : SrcCall;
                        state_q  <= StPush;
                        busy     <= 1'b1;
                        stk_en   <= 1'b1;
                        stk_push <= 1'b1;
                    end else if (ret_req) begin
                        // Stack top is the return address before the pop happens
                        ret_pc   <= stk_top;
                        retfie_q <= retfie;
                        kind_q   <= SrcRet;
                        state_q  <= StPop;
                        busy     <= 1'b1;
`ifdef STACK_CTRL_DEPTH_CHECK_EN
                        if (depth == '0) begin
                            unf_q <= 1'b1;
                        end else begin
                            stk_en  <= 1'b1;
                            stk_pop <= 1'b1;
                        end
`else
                        stk_en  <= 1'b1;
                        stk_pop <= 1'b1;
`endif
                    end
                end
                StPush: begin
                    if (depth == DepthMax) begin
                        // Stack drops its oldest entry; count stays saturated
                        ovf_q <= 1'b1;
                    end else begin
                        depth <= depth + 4'd1;
                    end
                    state_q <= StLoad;
                    pc_load <= 1'b1;
                    ack     <= 1'b1;
                    pc_src  <= kind_q;
                    gie_clr <= (kind_q == SrcInt);
                end
                StPop: begin
                    if (depth != '0) begin
                        depth <= depth - 4'd1;
                    end
                    state_q <= StLoad;
                    pc_load <= 1'b1;
                    ack     <= 1'b1;
                    pc_src  <= SrcRet;
                    gie_set <= retfie_q;
                end
                StLoad: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: scoreboard of expected LOAD-cycle results,
// pushed when a request is driven and popped when ack is observed.
module tb_stack_ctrl;

`ifdef STACK_CTRL_DEPTH_CHECK_EN
    localparam bit CheckEn = 1'b1;
`else
    localparam bit CheckEn = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       call_req = 1'b0, ret_req = 1'b0, retfie = 1'b0, int_req = 1'b0;
    logic [9:0] cur_pc = '0, stk_top = '0;
    logic [9:0] push_pc, ret_pc;
    logic       stk_en, stk_push, stk_pop, pc_load, ack, busy, gie_clr, gie_set;
    logic [1:0] pc_src;
    logic [3:0] depth;
    logic       overflow, underflow;

    stack_ctrl dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .call_req (call_req),
        .ret_req  (ret_req),
        .retfie   (retfie),
        .int_req  (int_req),
        .cur_pc   (cur_pc),
        .stk_top  (stk_top),
        .push_pc  (push_pc),
        .stk_en   (stk_en),
        .stk_push (stk_push),
        .stk_pop  (stk_pop),
        .pc_load  (pc_load),
        .pc_src   (pc_src),
        .ret_pc   (ret_pc),
        .ack      (ack),
        .busy     (busy),
        .gie_clr  (gie_clr),
        .gie_set  (gie_set),
        .depth    (depth),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] src;
        logic       gclr;
        logic       gset;
        logic [3:0] dep;
        logic [9:0] addr;
        logic       is_ret;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   md = 0;
    bit   m_ovf = 1'b0;
    bit   m_unf = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: depth counter, sticky flags, expected LOAD-cycle outputs
    task automatic expect_push(input logic [1:0] src, input logic [9:0] pc);
        exp_t e;
        if (md == 8) begin
            if (CheckEn) m_ovf = 1'b1;
        end else begin
            md++;
        end
        e.src = src; e.gclr = (src == 2'b10); e.gset = 1'b0; e.dep = 4'(md);
        e.addr = pc; e.is_ret = 1'b0; e.ovf = m_ovf; e.unf = m_unf;
        sb.push_back(e);
    endtask

    task automatic expect_pop(input logic [9:0] top, input bit rf);
        exp_t e;
        if (md == 0) begin
            if (CheckEn) m_unf = 1'b1;
        end else begin
            md--;
        end
        e.src = 2'b11; e.gclr = 1'b0; e.gset = rf; e.dep = 4'(md);
        e.addr = top; e.is_ret = 1'b1; e.ovf = m_ovf; e.unf = m_unf;
        sb.push_back(e);
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge clock) begin
        if (reset_n) begin
            check("no_overlap", 32'(stk_push & stk_pop), 0);
            if (ack) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("pc_load", 32'(pc_load), 1);
                    check("busy_load", 32'(busy), 1);
                    check("pc_src", 32'(pc_src), 32'(mon_e.src));
                    check("gie_clr", 32'(gie_clr), 32'(mon_e.gclr));
                    check("gie_set", 32'(gie_set), 32'(mon_e.gset));
                    check("depth", 32'(depth), 32'(mon_e.dep));
                    check(mon_e.is_ret ? "ret_pc" : "push_pc",
                          32'(mon_e.is_ret ? ret_pc : push_pc), 32'(mon_e.addr));
                    check("overflow", 32'(overflow), 32'(mon_e.ovf));
                    check("underflow", 32'(underflow), 32'(mon_e.unf));
                end
            end else begin
                check("idle_out", 32'({gie_clr, gie_set, pc_load, pc_src}), 0);
            end
        end
    end

    task automatic wait_ack(output int n);
        n = 0;
        for (int i = 1; i <= 8 && n == 0; i++) begin
            @(negedge clock);
            if (ack) n = i;
        end
        if (n == 0) check("ack_timeout", 0, 1);
    endtask

    task automatic do_call(input logic [9:0] pc);
        int n;
        @(negedge clock);
        cur_pc = pc;
        expect_push(2'b01, pc);
        call_req = 1'b1;
        @(negedge clock);
        check("call_strobe", 32'({stk_en, stk_push, stk_pop, busy}), 32'b1101);
        check("call_push_pc", 32'(push_pc), 32'(pc));
        wait_ack(n);
        check("call_latency", n, 1);
        call_req = 1'b0;
    endtask

    task automatic do_ret(input logic [9:0] top, input bit rf);
        int n;
        logic en;
        @(negedge clock);
        en = CheckEn ? (md != 0) : 1'b1;
        stk_top = top;
        retfie = rf;
        expect_pop(top, rf);
        ret_req = 1'b1;
        @(negedge clock);
        stk_top = ~top;   // ret_pc must hold the value captured at accept
        check("ret_strobe", 32'({stk_en, stk_push, stk_pop, busy}), 32'({en, 1'b0, en, 1'b1}));
        check("ret_pc_pop", 32'(ret_pc), 32'(top));
        wait_ack(n);
        check("ret_latency", n, 1);
        ret_req = 1'b0;
        retfie = 1'b0;
    endtask

    initial begin
        int n;
        #3;
        check("rst_strobes", 32'({stk_en, stk_push, stk_pop, pc_load, ack, gie_clr, gie_set}), 0);
        check("rst_misc", 32'({pc_src, busy, overflow, underflow, depth}), 0);
        check("rst_addrs", 32'({push_pc, ret_pc}), 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Basic CALL / RETURN pairs
        do_call(10'h123);
        do_call(10'h050);
        do_ret(10'h050, 1'b0);
        do_ret(10'h123, 1'b0);

        // Simultaneous INT and CALL: INT first, CALL accepted right after INT's LOAD
        @(negedge clock);
        cur_pc = 10'h2AA;
        expect_push(2'b10, 10'h2AA);
        expect_push(2'b01, 10'h155);
        int_req = 1'b1;
        call_req = 1'b1;
        @(negedge clock);
        check("int_strobe", 32'({stk_en, stk_push, stk_pop}), 32'b110);
        wait_ack(n);
        check("int_latency", n, 1);
        int_req = 1'b0;
        cur_pc = 10'h155;
        wait_ack(n);
        check("call_after_int", n, 3);
        call_req = 1'b0;

        // Fill past the top: 2 + 7 = 9 pushes
        for (int i = 0; i < 7; i++) do_call(10'(10'h200 + i));
        @(negedge clock);
        check("depth_sat", 32'(depth), 8);
        check("overflow_flag", 32'(overflow), 32'(CheckEn));

        // Drain to empty, then RETFIE on an empty stack
        for (int i = 0; i < 8; i++) do_ret(10'(10'h300 + i), 1'b0);
        do_ret(10'h3F0, 1'b1);
        @(negedge clock);
        check("underflow_flag", 32'(underflow), 32'(CheckEn));
        check("depth_empty", 32'(depth), 0);

        // Reset in the PUSH cycle aborts at once
        @(negedge clock);
        cur_pc = 10'h0AB;
        call_req = 1'b1;
        @(negedge clock);
        check("pre_rst_push", 32'(stk_push), 1);
        #1 reset_n = 1'b0;
        #1;
        check("abort_strobes", 32'({stk_en, stk_push, stk_pop, ack, pc_load}), 0);
        check("abort_state", 32'({busy, depth, overflow, underflow}), 0);
        call_req = 1'b0;
        md = 0; m_ovf = 1'b0; m_unf = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("post_rst_quiet", 32'({ack, busy, stk_en}), 0);
        end
        do_call(10'h077);

        repeat (2) @(negedge clock);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
